fixed_point_addsub_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's combinational fixed-point subtractor.
- Signed two's-complement Qm.Q operands; per-transaction add/subtract select; overflow detection.
- Valid/ready handshake on both sides, so it drops into streaming datapaths (filters, accumulators) between producer and consumer stages.
- Fixed 2-cycle latency, full throughput (1 result/cycle) when not back-pressured.

---
 rtl/fixed_point_addsub_pipe_pkg.sv | 19 +
 rtl/fixed_point_addsub_pipe_if.sv | 32 +++
 rtl/fixed_point_addsub_pipe_sat_wrap.sv | 32 +++
 rtl/fixed_point_addsub_pipe.sv | 97 +++++++++
 tb/tb_fixed_point_addsub_pipe.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_point_addsub_pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : fxp_pkg                                                           |
// | Desc   : Shared op encoding and stage-1 record type for the fixed-point     |
// |          add/sub pipeline.                                                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

// Width-parametrised stage-1 record: N+1-bit sum plus its valid flag.
`ifndef FXP_S1_T
`define FXP_S1_T(W) struct packed { logic [(W):0] sum; logic valid; }
`endif

package fxp_pkg;
    localparam logic FXP_OP_SUB = 1'b0;
    localparam logic FXP_OP_ADD = 1'b1;
endpackage

`default_nettype wire

// File: rtl/fixed_point_addsub_pipe_if.sv
// +----------------------------------------------------------------------------+
// | Module : fixed_point_addsub_pipe_if                                        |
// | Desc   : Operand/result valid-ready bus for the fixed-point add/sub pipe.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fixed_point_addsub_pipe_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_c;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_c, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_c, out_ovf
    );
endinterface

`default_nettype wire

// File: rtl/fixed_point_addsub_pipe_sat_wrap.sv
// +----------------------------------------------------------------------------+
// | Module : fxp_sat_wrap                                                      |
// | Desc   : Narrows an N+1-bit sum to N bits with overflow flag; saturates    |
// |          when FXP_ADDSUB_SAT_EN is defined, wraps otherwise.               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fxp_sat_wrap #(
    parameter int N = 16
) (
    input  wire logic [N:0]   i_sum,
    output logic      [N-1:0] o_c,
    output logic              o_ovf
);
    // The two top bits disagree exactly when the value needs N+1 bits.
    assign o_ovf = i_sum[N] ^ i_sum[N-1];

`ifdef FXP_ADDSUB_SAT_EN
    always_comb begin
        o_c = i_sum[N-1:0];
        if (o_ovf) begin
            o_c = {i_sum[N], {(N-1){~i_sum[N]}}};
        end
    end
`else
    assign o_c = i_sum[N-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/fixed_point_addsub_pipe.sv
// +----------------------------------------------------------------------------+
// | Module : fixed_point_addsub_pipe                                           |
// | Desc   : Two-stage valid/ready signed Qm.Q add/subtract with overflow.     |
// |          Optional saturation: define FXP_ADDSUB_SAT_EN.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fixed_point_addsub_pipe
    import fxp_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 8
) (
    input wire logic                 clk,
    input wire logic                 rst_n,
    fixed_point_addsub_pipe_if.slave bus
);
    typedef `FXP_S1_T(N) s1_t;

    // Q only fixes the binary point for the user; the arithmetic is scale-free.
    if (Q >= N || N < 4) begin : g_param_range_bad
    end

    s1_t          r_s1;
    logic         r_s2_valid;
    logic [N-1:0] r_out_c;
    logic         r_out_ovf;

    logic         w_adv1;
    logic         w_adv2;
    logic         w_in_xfer;
    logic [N:0]   w_ext_a;
    logic [N:0]   w_ext_b;
    logic [N:0]   w_b_term;
    logic [N:0]   w_sum;
    logic [N-1:0] w_c;
    logic         w_ovf;

    assign w_adv2    = ~r_s2_valid | bus.out_ready;
    assign w_adv1    = ~r_s1.valid | w_adv2;
    assign w_in_xfer = bus.in_valid & w_adv1;

    assign w_ext_a = {bus.in_a[N-1], bus.in_a};
    assign w_ext_b = {bus.in_b[N-1], bus.in_b};

    // At N+1 bits negating the most negative N-bit value is exact.
    always_comb begin
        w_b_term = w_ext_b;
        unique case (bus.in_op)
            FXP_OP_ADD: w_b_term = w_ext_b;
            FXP_OP_SUB: w_b_term = -w_ext_b;
        endcase
    end

    assign w_sum = w_ext_a + w_b_term;

    fxp_sat_wrap #(
        .N (N)
    ) u_sat_wrap (
        .i_sum (r_s1.sum),
        .o_c   (w_c),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1       <= '0;
            r_s2_valid <= 1'b0;
            r_out_c    <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_s1.sum   <= w_sum;
                r_s1.valid <= 1'b1;
            end else if (w_adv1) begin
                r_s1.valid <= 1'b0;
            end

            if (w_adv2) begin
                r_s2_valid <= r_s1.valid;
                if (r_s1.valid) begin
                    r_out_c   <= w_c;
                    r_out_ovf <= w_ovf;
                end
            end
        end
    end

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_c     = r_out_c;
    assign bus.out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_addsub_pipe.sv
// +----------------------------------------------------------------------------+
// | Module : tb_fixed_point_addsub_pipe                                        |
// | Desc   : Randomised self-checking bench with an arithmetic reference model.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fixed_point_addsub_pipe;
    localparam int N = 16;
    localparam int Q = 8;
    localparam int MAXP = (1 << (N-1)) - 1;
    localparam int MINN = -(1 << (N-1));

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   rcv;
    logic [N:0] exp_q[$];

    fixed_point_addsub_pipe_if #(.N(N)) bif ();

    fixed_point_addsub_pipe #(.N(N), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer result, then range-check and narrow.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic op);
        int          sa;
        int          sb;
        int          r;
        logic        ovf;
        logic [31:0] rv;
        sa  = $signed(a);
        sb  = $signed(b);
        r   = op ? sa + sb : sa - sb;
        ovf = (r > MAXP) || (r < MINN);
`ifdef FXP_ADDSUB_SAT_EN
        if (r > MAXP) r = MAXP;
        if (r < MINN) r = MINN;
`endif
        rv = r;
        return {ovf, rv[N-1:0]};
    endfunction

    // Scoreboard: decides at the falling edge what the next rising edge transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bif.in_valid && bif.in_ready)
                exp_q.push_back(model(bif.in_a, bif.in_b, bif.in_op));
            if (bif.out_valid && bif.out_ready) begin
                rcv++;
                if (exp_q.size() == 0)
                    chk("unexpected_out", 32'(bif.out_valid), 32'd0);
                else
                    chk("result", 32'({bif.out_ovf, bif.out_c}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic op);
        bit ok;
        ok = 0;
        bif.in_a = a;
        bif.in_b = b;
        bif.in_op = op;
        bif.in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bif.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd1, 32'd0);
        tick();
        bif.in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic op, input logic [N-1:0] c, input logic ovf);
        send(a, b, op);
        chk({tag, "_early"}, 32'(bif.out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bif.out_valid), 32'd1);
        chk({tag, "_c"}, 32'(bif.out_c), 32'(c));
        chk({tag, "_ovf"}, 32'(bif.out_ovf), 32'(ovf));
        tick();
    endtask

    initial begin
        int          acc;
        int          stall;
        int          vcnt;
        int          rcv0;
        logic [N:0]  first;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        total = 0;
        bad = 0;
        rcv = 0;
        rst_n = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_a = '0;
        bif.in_b = '0;
        bif.in_op = 1'b0;
        bif.out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;

        chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_out_c", 32'(bif.out_c), 32'd0);
        chk("rst_out_ovf", 32'(bif.out_ovf), 32'd0);

        directed("sub_frac", 16'h0180, 16'h0240, 1'b0, 16'hFF40, 1'b0);
`ifdef FXP_ADDSUB_SAT_EN
        directed("add_ovf", 16'h7F00, 16'h0200, 1'b1, 16'h7FFF, 1'b1);
        directed("sub_ovf", 16'h8000, 16'h0100, 1'b0, 16'h8000, 1'b1);
`else
        directed("add_ovf", 16'h7F00, 16'h0200, 1'b1, 16'h8100, 1'b1);
        directed("sub_ovf", 16'h8000, 16'h0100, 1'b0, 16'h7F00, 1'b1);
`endif
        directed("sub_zero", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0);
        directed("sub_min", 16'h0000, 16'h8000, 1'b0, model(16'h0000, 16'h8000, 1'b0), 1'b1);

        // Back-pressure: only two slots exist.
        bif.out_ready = 1'b0;
        acc = 0;
        first = model(16'h0101, 16'h0010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bif.in_valid = 1'b1;
            bif.in_a = 16'(16'h0101 * (i + 1));
            bif.in_b = 16'(16'h0010 * (i + 1));
            bif.in_op = 1'b1;
            @(negedge clk);
            if (bif.in_ready) acc++;
            tick();
        end
        bif.in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
        repeat (3) tick();
        chk("bp_hold_valid", 32'(bif.out_valid), 32'd1);
        chk("bp_hold_c", 32'(bif.out_c), 32'(first[N-1:0]));
        rcv0 = rcv;
        bif.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain0", 32'(bif.out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("bp_drain1", 32'(bif.out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("bp_drain2", 32'(bif.out_valid), 32'd0);
        chk("bp_count", 32'(rcv - rcv0), 32'd2);
        tick();

        // Full-rate stream.
        stall = 0;
        rcv0 = rcv;
        for (int i = 0; i < 32; i++) begin
            bif.in_valid = 1'b1;
            bif.in_a = 16'($urandom);
            bif.in_b = 16'($urandom);
            bif.in_op = 1'($urandom);
            @(negedge clk);
            if (!bif.in_ready) stall++;
            tick();
        end
        bif.in_valid = 1'b0;
        repeat (4) tick();
        chk("stream_stalls", 32'(stall), 32'd0);
        chk("stream_count", 32'(rcv - rcv0), 32'd32);

        // Random valid/ready on both sides, protocol-correct producer.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            acc = int'(bif.in_valid && bif.in_ready);
            tick();
            bif.out_ready = ($urandom_range(0, 3) != 0);
            if (!bif.in_valid || acc != 0) begin
                bif.in_valid = 1'($urandom);
                ra = 16'($urandom);
                rb = 16'($urandom);
                if ($urandom_range(0, 7) == 0) ra = 16'h8000;
                if ($urandom_range(0, 7) == 0) rb = 16'h7FFF;
                bif.in_a = ra;
                bif.in_b = rb;
                bif.in_op = 1'($urandom);
            end
        end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        repeat (4) tick();
        chk("random_drain", 32'(exp_q.size()), 32'd0);

        // Mid-flight reset discards both stages.
        bif.out_ready = 1'b0;
        send(16'h0111, 16'h0222, 1'b1);
        send(16'h0333, 16'h0444, 1'b0);
        chk("flush_full", 32'(bif.in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("flush_out_valid", 32'(bif.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bif.in_ready), 32'd1);
        bif.out_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bif.out_valid) vcnt++;
            tick();
        end
        chk("flush_stale", 32'(vcnt), 32'd0);
        chk("leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
